control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_pkg.sv | 105 ++++++++++
 rtl/control_fsm_alu_decoder.sv | 31 +++
 rtl/control_fsm.sv | 103 ++++++++++
 tb/tb_control_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// Shared types and constants for the multicycle control FSM:
// state encoding, ALU operation codes, opcodes and the per-state Moore control word.
package control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef struct packed {
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      aluop_t     aluop;
      logic       branch;
   } ctrl_t;

   // Moore control word for a state; anything not set stays zero.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.irwrite   = 1'b1;
            c.pcwrite   = 1'b1;
            c.alusrcb   = 2'b10;
            c.resultsrc = 2'b10;
         end
         S_DECODE: begin
            c.alusrca = 2'b01;
            c.alusrcb = 2'b01;
         end
         S_MEMADR: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
         end
         S_MEMREAD:  c.adrsrc = 1'b1;
         S_MEMWB: begin
            c.resultsrc = 2'b01;
            c.regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adrsrc   = 1'b1;
            c.memwrite = 1'b1;
         end
         S_EXECUTER: begin
            c.alusrca = 2'b10;
            c.aluop   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
            c.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB:    c.regwrite = 1'b1;
         S_BEQ: begin
            c.alusrca = 2'b10;
            c.aluop   = ALUOP_SUB;
            c.branch  = 1'b1;
         end
         S_JAL: begin
            c.alusrca = 2'b01;
            c.alusrcb = 2'b10;
            c.pcwrite = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// ALU operation decode from the FSM's ALUOp and the instruction's funct fields.
module alu_decoder
   import control_fsm_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // sub only for register-register ops; addi ignores bit 30
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alucontrol = ALU_SLT;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V control unit: state register, next-state logic and registered
// Moore outputs, with the branch enable gated by Zero and ALU decode in a sub-module.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] State
);

   state_t state_reg;
   state_t state_next;
   ctrl_t  ctrl_reg;
   ctrl_t  ctrl_out;

   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTER;
               OP_ITYPE:     state_next = S_EXECUTEI;
               OP_BEQ:       state_next = S_BEQ;
               OP_JAL:       state_next = S_JAL;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR:  state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_next = S_MEMWB;
         S_EXECUTER, S_EXECUTEI, S_JAL: state_next = S_ALUWB;
         default:   state_next = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state so they are glitch-free in-state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_FETCH;
         ctrl_reg  <= state_ctrl(S_FETCH);
      end else begin
         state_reg <= state_next;
         ctrl_reg  <= state_ctrl(state_next);
      end
   end

   // Reset overrides immediately, not at the next edge, so no write can slip out.
   always_comb begin
      ctrl_out = ctrl_reg;
      if (!rst_n) begin
         ctrl_out          = state_ctrl(S_FETCH);
         ctrl_out.pcwrite  = 1'b0;
         ctrl_out.irwrite  = 1'b0;
         ctrl_out.regwrite = 1'b0;
         ctrl_out.memwrite = 1'b0;
      end
   end

   assign PCWrite   = ctrl_out.pcwrite | (ctrl_out.branch & Zero);
   assign AdrSrc    = ctrl_out.adrsrc;
   assign MemWrite  = ctrl_out.memwrite;
   assign IRWrite   = ctrl_out.irwrite;
   assign RegWrite  = ctrl_out.regwrite;
   assign ResultSrc = ctrl_out.resultsrc;
   assign ALUSrcA   = ctrl_out.alusrca;
   assign ALUSrcB   = ctrl_out.alusrcb;
   assign State     = rst_n ? state_reg : S_FETCH;

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_LW, OP_ITYPE: ImmSrc = 2'b00;
         OP_SW:           ImmSrc = 2'b01;
         OP_BEQ:          ImmSrc = 2'b10;
         OP_JAL:          ImmSrc = 2'b11;
         default:         ImmSrc = 2'b00;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (ctrl_out.aluop),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .alucontrol (ALUControl)
   );

endmodule

// File: tb/tb_control_fsm.sv
// Randomized and directed check of control_fsm against an instruction-level model:
// expected state sequences by instruction class and per-state control values.
module tb_control_fsm;
   import control_fsm_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control_fsm dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .State(State)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] exp_imm(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b0010011: return 2'b00;
         7'b0100011:             return 2'b01;
         7'b1100011:             return 2'b10;
         7'b1101111:             return 2'b11;
         default:                return 2'b00;
      endcase
   endfunction

   // kind: 0 = add, 1 = subtract, 2 = chosen by funct fields
   function automatic logic [2:0] exp_alu(input int kind, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7);
      if (kind == 1) return 3'b001;
      if (kind == 0) return 3'b000;
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   task automatic check_state(input state_t s, input string nm);
      logic pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb;
      int kind;
      {pcw, adr, mw, irw, rw} = '0;
      rs = 2'b00; sa = 2'b00; sb = 2'b00; kind = 0;
      case (s)
         S_FETCH:    begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
         S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
         S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         S_MEMREAD:  adr = 1;
         S_MEMWB:    begin rs = 2'b01; rw = 1; end
         S_MEMWRITE: begin adr = 1; mw = 1; end
         S_EXECUTER: begin sa = 2'b10; kind = 2; end
         S_EXECUTEI: begin sa = 2'b10; sb = 2'b01; kind = 2; end
         S_ALUWB:    rw = 1;
         S_BEQ:      begin sa = 2'b10; kind = 1; pcw = Zero; end
         S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         default:    ;
      endcase
      check_eq({nm, ".State"},      32'(State),      32'(s));
      check_eq({nm, ".PCWrite"},    32'(PCWrite),    32'(pcw));
      check_eq({nm, ".AdrSrc"},     32'(AdrSrc),     32'(adr));
      check_eq({nm, ".MemWrite"},   32'(MemWrite),   32'(mw));
      check_eq({nm, ".IRWrite"},    32'(IRWrite),    32'(irw));
      check_eq({nm, ".RegWrite"},   32'(RegWrite),   32'(rw));
      check_eq({nm, ".ResultSrc"},  32'(ResultSrc),  32'(rs));
      check_eq({nm, ".ALUSrcA"},    32'(ALUSrcA),    32'(sa));
      check_eq({nm, ".ALUSrcB"},    32'(ALUSrcB),    32'(sb));
      check_eq({nm, ".ImmSrc"},     32'(ImmSrc),     32'(exp_imm(op)));
      check_eq({nm, ".ALUControl"}, 32'(ALUControl), 32'(exp_alu(kind, op, funct3, funct7b5)));
   endtask

   task automatic check_reset(input string nm);
      check_eq({nm, ".State"},      32'(State),      32'(S_FETCH));
      check_eq({nm, ".PCWrite"},    32'(PCWrite),    32'd0);
      check_eq({nm, ".IRWrite"},    32'(IRWrite),    32'd0);
      check_eq({nm, ".RegWrite"},   32'(RegWrite),   32'd0);
      check_eq({nm, ".MemWrite"},   32'(MemWrite),   32'd0);
      check_eq({nm, ".AdrSrc"},     32'(AdrSrc),     32'd0);
      check_eq({nm, ".ResultSrc"},  32'(ResultSrc),  32'd2);
      check_eq({nm, ".ALUSrcA"},    32'(ALUSrcA),    32'd0);
      check_eq({nm, ".ALUSrcB"},    32'(ALUSrcB),    32'd2);
      check_eq({nm, ".ALUControl"}, 32'(ALUControl), 32'd0);
      check_eq({nm, ".ImmSrc"},     32'(ImmSrc),     32'(exp_imm(op)));
   endtask

   // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
   // zmode: 0 = Zero low, 1 = Zero high, 2 = random each cycle.
   task automatic run_insn(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input string nm);
      state_t q[$];
      q = '{S_FETCH, S_DECODE};
      case (o)
         7'b0000011: q = {q, S_MEMADR, S_MEMREAD, S_MEMWB};
         7'b0100011: q = {q, S_MEMADR, S_MEMWRITE};
         7'b0110011: q = {q, S_EXECUTER, S_ALUWB};
         7'b0010011: q = {q, S_EXECUTEI, S_ALUWB};
         7'b1100011: q.push_back(S_BEQ);
         7'b1101111: q = {q, S_JAL, S_ALUWB};
         default:    ;
      endcase
      op = o; funct3 = f3; funct7b5 = f7;
      for (int k = 0; k < q.size(); k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         @(negedge clk);
         check_state(q[k], $sformatf("%s[%0d]", nm, k));
      end
      @(posedge clk);
      #1;
      $display("INSN %s op=%b f3=%b f7b5=%b cycles=%0d", nm, o, f3, f7, q.size());
   endtask

   initial begin
      rst_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_reset("rst_init");
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_insn(7'b0000011, 3'b010, 1'b0, 2, "lw");
      run_insn(7'b0100011, 3'b010, 1'b1, 2, "sw");
      run_insn(7'b0110011, 3'b000, 1'b1, 2, "r_sub");
      run_insn(7'b0110011, 3'b000, 1'b0, 2, "r_add");
      run_insn(7'b0110011, 3'b010, 1'b0, 2, "r_slt");
      run_insn(7'b0010011, 3'b000, 1'b1, 2, "i_addi");
      run_insn(7'b1100011, 3'b000, 1'b0, 1, "beq_taken");
      run_insn(7'b1100011, 3'b000, 1'b0, 0, "beq_not");
      run_insn(7'b1111111, 3'b000, 1'b0, 2, "unsup");
      run_insn(7'b1101111, 3'b000, 1'b0, 2, "jal");

      // Reset asserted in MEMWRITE and held across three edges.
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_eq("pre_rst.State", 32'(State), 32'(S_MEMWRITE));
      check_eq("pre_rst.MemWrite", 32'(MemWrite), 32'd1);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset($sformatf("rst_memwrite%0d", i));
         @(posedge clk);
      end
      #1;
      rst_n = 1'b1;
      run_insn(7'b0110011, 3'b111, 1'b0, 2, "post_rst_and");

      for (int n = 0; n < 150; n++) begin
         logic [6:0] o;
         int cls;
         cls = $urandom_range(0, 6);
         case (cls)
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1100011;
            5: o = 7'b1101111;
            default: begin
               o = 7'($urandom_range(0, 127));
               while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                      o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111)
                  o = 7'($urandom_range(0, 127));
            end
         endcase
         run_insn(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2,
                  $sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
